// File: rtl/arilla_bus_pkg.sv
// Shared types and width helpers for the arilla bus RAM responder.
// Imported by the bus interface, the RAM array and the responder top.
package arilla_bus_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_RESP
    } resp_state_e;

    // The bus carries word addresses: byte address minus the byte-offset bits.
    function automatic int word_addr_w(input int addr_w, input int data_w);
        return addr_w - $clog2(data_w / BYTE_W);
    endfunction

    function automatic int byte_lanes(input int data_w);
        return data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/arilla_bus_if.sv
// Arilla bus: word address, byte enables, read/write strobes and a shared tristate data bus.
// Each side owns a value/enable pair; the shared net is resolved here.
interface arilla_bus_if
    import arilla_bus_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
);
    localparam int WordAddrW = word_addr_w(AddressWidth, DataWidth);
    localparam int Lanes     = byte_lanes(DataWidth);

    logic [WordAddrW-1:0] address;
    logic [Lanes-1:0]     byte_enable;
    logic                 read;
    logic                 write;
    logic [DataWidth-1:0] mst_data;
    logic                 mst_oe;
    logic [DataWidth-1:0] resp_data;
    logic                 resp_oe;
    wire  [DataWidth-1:0] data;

    assign data = mst_oe  ? mst_data  : 'z;
    assign data = resp_oe ? resp_data : 'z;

    modport master (
        output address, byte_enable, read, write, mst_data, mst_oe,
        input  data, resp_oe
    );

    modport slave (
        input  address, byte_enable, read, write, data,
        output resp_data, resp_oe
    );

endinterface

// File: rtl/arilla_ram_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Read data holds its value until the next read strobe.
module arilla_ram_array
    import arilla_bus_pkg::*;
#(
    parameter int DataWidth  = 32,
    parameter int DepthWords = 1024,
    localparam int Lanes     = byte_lanes(DataWidth),
    localparam int IdxW      = $clog2(DepthWords)
) (
    input  logic                 clk,
    input  logic [Lanes-1:0]     we,
    input  logic                 re,
    input  logic [IdxW-1:0]      addr,
    input  logic [DataWidth-1:0] wdata,
    output logic [DataWidth-1:0] rdata
);

    logic [DataWidth-1:0] mem [DepthWords];

    always_ff @(posedge clk) begin
        for (int j = 0; j < Lanes; j++) begin
            if (we[j]) begin
                mem[addr][j*BYTE_W +: BYTE_W] <= wdata[j*BYTE_W +: BYTE_W];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/arilla_bus_ram_responder.sv
// Arilla bus responder backed by on-chip RAM: window decode, byte-enabled writes,
// one-cycle-latency reads driven onto the shared bus, optional clear sweep after reset.
module arilla_bus_ram_responder
    import arilla_bus_pkg::*;
#(
    parameter int          DataWidth    = 32,
    parameter int          AddressWidth = 32,
    parameter int unsigned BaseWord     = 0,
    parameter int          DepthWords   = 1024,
    parameter bit          ClearOnReset = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    arilla_bus_if.slave  bus_interface,
    output logic         init_done,
    output logic         protocol_error
);

    localparam int WordAddrW = word_addr_w(AddressWidth, DataWidth);
    localparam int Lanes     = byte_lanes(DataWidth);
    localparam int IdxW      = $clog2(DepthWords);

    resp_state_e          state_q, state_d;
    logic [IdxW-1:0]      clear_ptr;
    logic                 clear_last;
    logic [WordAddrW-1:0] off;
    logic                 hit;
    logic                 set_err;
    logic                 vld_p1;
    logic [Lanes-1:0]     ram_we;
    logic                 ram_re;
    logic [IdxW-1:0]      ram_addr;
    logic [DataWidth-1:0] ram_wdata;
    logic [DataWidth-1:0] ram_rdata;

    // Unsigned wrap makes addresses below BaseWord decode as misses.
    assign off        = bus_interface.address - WordAddrW'(BaseWord);
    assign hit        = init_done && (off < WordAddrW'(DepthWords));
    assign clear_last = (clear_ptr == IdxW'(DepthWords - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ClearOnReset ? ST_CLEAR : ST_IDLE;
            clear_ptr      <= '0;
            init_done      <= !ClearOnReset;
            protocol_error <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_CLEAR) begin
                clear_ptr <= clear_ptr + 1'b1;
                if (clear_last) init_done <= 1'b1;
            end
            if (set_err) protocol_error <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        ram_we    = '0;
        ram_re    = 1'b0;
        ram_addr  = off[IdxW-1:0];
        ram_wdata = bus_interface.data;
        set_err   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                ram_we    = '1;
                ram_addr  = clear_ptr;
                ram_wdata = '0;
                if (clear_last) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (hit && bus_interface.write) begin
                    ram_we  = bus_interface.byte_enable;
                    set_err = bus_interface.read;
                end else if (hit && bus_interface.read) begin
                    ram_re  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                set_err = bus_interface.read || bus_interface.write;
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst) ram_we = '0;
    end

    // Response stage: the drive enable comes straight from the registered state.
    assign vld_p1                  = (state_q == ST_RESP);
    assign bus_interface.resp_oe   = vld_p1;
    assign bus_interface.resp_data = ram_rdata;

    arilla_ram_array #(
        .DataWidth  (DataWidth),
        .DepthWords (DepthWords)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_arilla_bus_ram_responder.sv
// Randomised scoreboard bench for the arilla bus RAM responder against a word-array model.
module tb_arilla_bus_ram_responder;

    localparam int          DW    = 32;
    localparam int          AW    = 32;
    localparam int unsigned BASE  = 32'h40;
    localparam int          DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    logic init_done;
    logic protocol_error;

    always #5 clk = ~clk;

    arilla_bus_if #(.DataWidth(DW), .AddressWidth(AW)) bus ();

    arilla_bus_ram_responder #(
        .DataWidth    (DW),
        .AddressWidth (AW),
        .BaseWord     (BASE),
        .DepthWords   (DEPTH),
        .ClearOnReset (1'b1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus_interface  (bus),
        .init_done      (init_done),
        .protocol_error (protocol_error)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    exp_t        exp_q[$];
    logic [31:0] mem_m [DEPTH];
    bit          err_m;
    bit          ready_m;
    int          last_rd;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares every cycle's drive enable and, when driven, the bus word.
    always @(negedge clk) begin : monitor
        exp_t e;
        bit   exp_oe;
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                e = exp_q.pop_front();
                check("stale_response", 32'(e.due), 32'(cyc));
            end
            exp_oe = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            check("resp_oe", 32'(bus.resp_oe), 32'(exp_oe));
            if (exp_oe) begin
                e = exp_q.pop_front();
                if (bus.resp_oe) check("resp_data", bus.data, e.data);
            end
        end
    end

    task automatic drive_idle();
        bus.read        = 1'b0;
        bus.write       = 1'b0;
        bus.mst_oe      = 1'b0;
        bus.address     = '0;
        bus.byte_enable = '0;
        bus.mst_data    = '0;
    endtask

    // One bus cycle: drive the command, update the model, step the clock, check status.
    task automatic cmd(input bit rd, input bit wr, input int unsigned waddr,
                       input logic [3:0] be, input logic [31:0] wd);
        bit          in_resp;
        bit          hit;
        int unsigned idx;
        in_resp = (last_rd == cyc - 1);
        hit     = ready_m && (waddr >= BASE) && (waddr < BASE + DEPTH);
        idx     = waddr - BASE;
        bus.read        = rd;
        bus.write       = wr;
        bus.address     = waddr[29:0];
        bus.byte_enable = be;
        bus.mst_data    = wd;
        bus.mst_oe      = wr && !in_resp;
        if (in_resp) begin
            if (rd || wr) err_m = 1'b1;
        end else if (hit) begin
            if (wr) begin
                for (int j = 0; j < 4; j++)
                    if (be[j]) mem_m[idx][8*j +: 8] = wd[8*j +: 8];
                if (rd) err_m = 1'b1;
            end else if (rd) begin
                exp_q.push_back('{cyc + 1, mem_m[idx]});
                last_rd = cyc;
            end
        end
        @(posedge clk); #1;
        drive_idle();
        check("protocol_error", 32'(protocol_error), 32'(err_m));
        check("init_done", 32'(init_done), 32'(ready_m));
    endtask

    task automatic idle(input int n);
        repeat (n) cmd(1'b0, 1'b0, 0, 4'h0, 32'h0);
    endtask

    task automatic do_reset();
        int n;
        drive_idle();
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        err_m   = 1'b0;
        ready_m = 1'b0;
        last_rd = -10;
        mon_en  = 1'b1;
        check("rst_protocol_error", 32'(protocol_error), 32'h0);
        check("rst_init_done", 32'(init_done), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        while (!init_done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("clear_cycles", 32'(n), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
        ready_m = 1'b1;
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) begin
            cmd(1'b1, 1'b0, BASE + i, 4'h0, 32'h0);
            idle(1);
        end
    endtask

    initial begin
        drive_idle();
        rst     = 1'b1;
        err_m   = 1'b0;
        ready_m = 1'b0;
        last_rd = -10;

        do_reset();
        read_all();

        cmd(1'b0, 1'b1, BASE + 3, 4'b1111, 32'hDEADBEEF);
        cmd(1'b1, 1'b0, BASE + 3, 4'b0000, 32'h0);
        idle(2);

        cmd(1'b0, 1'b1, BASE + 3, 4'b0010, 32'h0000AB00);
        cmd(1'b1, 1'b0, BASE + 3, 4'b1111, 32'h0);
        idle(2);

        cmd(1'b1, 1'b0, BASE + DEPTH, 4'h0, 32'h0);
        cmd(1'b1, 1'b0, BASE - 1, 4'h0, 32'h0);
        idle(3);

        cmd(1'b0, 1'b1, BASE + 5, 4'b1111, 32'h12345678);
        cmd(1'b1, 1'b0, BASE + 5, 4'h0, 32'h0);
        cmd(1'b0, 1'b1, BASE + 5, 4'b1111, 32'hCAFEF00D);
        idle(1);
        cmd(1'b1, 1'b0, BASE + 5, 4'h0, 32'h0);
        idle(3);

        cmd(1'b1, 1'b0, BASE + 3, 4'h0, 32'h0);
        do_reset();
        cmd(1'b1, 1'b0, BASE + 3, 4'h0, 32'h0);
        idle(2);

        cmd(1'b0, 1'b1, BASE + 7, 4'b1111, 32'h0BADC0DE);
        cmd(1'b0, 1'b0, BASE + 7, 4'b0000, 32'h0);
        cmd(1'b1, 1'b1, BASE + 7, 4'b0001, 32'h000000FF);
        cmd(1'b1, 1'b0, BASE + 7, 4'h0, 32'h0);
        idle(2);

        do_reset();
        for (int k = 0; k < 400; k++) begin
            cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                BASE - 2 + $urandom_range(0, DEPTH + 3),
                4'($urandom), $urandom);
        end
        idle(2);
        read_all();
        idle(3);

        mon_en = 1'b0;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
